// File: rtl/cpu_write_checker.sv
// cpu_write_checker: on-board self-check monitor that sits beside the CPU.
// Watches the register-file and data-memory write ports, compares each
// architectural write in order against a loaded table of expected writes,
// then requires the CPU to reach HALT. The verdict, the failing table
// index, a failure code and a saturating cycle count are exported so the
// board can drive LEDs with them.
module cpu_write_checker #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int STRICT  = 1,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NE_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              load_kind,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [NE_W-1:0]   num_events,
  input  logic              rf_we,
  input  logic [REG_W-1:0]  rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              halted,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CODE_EXTRA    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HALTWAIT,
    S_PASS,
    S_FAIL
  } state_t;

  // One expected architectural write: kind 0 = register, 1 = memory.
  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            tbl_q [DEPTH];

  state_t            state_q, state_d;
  logic [NE_W-1:0]   ptr_q, ptr_d;
  logic [NE_W-1:0]   num_q, num_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Observed write event, folded into the same shape as a table entry.
  logic              ev_valid;
  logic              ev_double;
  entry_t            ev;
  entry_t            cur;
  logic              ka_match;
  logic              full_match;
  logic              bad_write;
  logic [NE_W-1:0]   ptr_inc;
  logic [TMR_W-1:0]  timer_inc;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt_inc;
  logic              armable;

  assign armable = (state_q == S_IDLE) || (state_q == S_PASS) || (state_q == S_FAIL);

  // Table load port; frozen while a check is running so the reference
  // cannot change under the comparison. Reset leaves the contents alone.
  always_ff @(posedge clk) begin
    if (load_we && armable) begin
      tbl_q[load_idx] <= '{kind: load_kind, addr: load_addr, data: load_data};
    end
  end

  // Decode the tap ports into a single event and compare against entry[ptr].
  always_comb begin
    ev_valid  = rf_we | mem_we;
    ev_double = rf_we & mem_we;
    ev.kind   = mem_we;
    ev.addr   = mem_we ? mem_waddr : ADDR_W'(rf_waddr);
    ev.data   = mem_we ? mem_wdata : rf_wdata;
    cur       = tbl_q[ptr_q[IDX_W-1:0]];
    ka_match  = ev_valid && (cur.kind == ev.kind) && (cur.addr == ev.addr);
    full_match = ka_match && (cur.data == ev.data);
    // Non-strict mode only objects when the right location gets wrong data.
    bad_write = ev_valid && !full_match && ((STRICT != 0) || ka_match);
    ptr_inc   = ptr_q + NE_W'(1);
    timer_inc = timer_q + TMR_W'(1);
    timeout_hit = (timer_inc == TMR_W'(TIMEOUT));
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state logic: arming, in-order matching, halt wait and verdicts.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          num_d   = num_events;
          ptr_d   = '0;
          timer_d = '0;
          cnt_d   = '0;
          code_d  = CODE_NONE;
          idx_d   = '0;
          state_d = (num_events == '0) ? S_HALTWAIT : S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        if (ev_double) begin
          state_d = S_FAIL;
          code_d  = CODE_EXTRA;
          idx_d   = ptr_q[IDX_W-1:0];
        end else if (bad_write) begin
          state_d = S_FAIL;
          code_d  = CODE_MISMATCH;
          idx_d   = ptr_q[IDX_W-1:0];
        end else if (full_match) begin
          ptr_d   = ptr_inc;
          timer_d = '0;
          if (ptr_inc == num_q) state_d = S_HALTWAIT;
        end else if (halted) begin
          // CPU stopped before producing every expected write.
          state_d = S_FAIL;
          code_d  = CODE_EXTRA;
          idx_d   = ptr_q[IDX_W-1:0];
        end else begin
          timer_d = timer_inc;
          if (timeout_hit) begin
            state_d = S_FAIL;
            code_d  = CODE_TIMEOUT;
            idx_d   = ptr_q[IDX_W-1:0];
          end
        end
      end

      S_HALTWAIT: begin
        cnt_d = cnt_inc;
        if ((STRICT != 0) && ev_valid) begin
          // Every expected write is done; anything further is extra.
          state_d = S_FAIL;
          code_d  = CODE_EXTRA;
          idx_d   = ptr_q[IDX_W-1:0];
        end else if (halted) begin
          state_d = S_PASS;
        end else begin
          timer_d = timer_inc;
          if (timeout_hit) begin
            state_d = S_FAIL;
            code_d  = CODE_TIMEOUT;
            idx_d   = ptr_q[IDX_W-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      num_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      code_q  <= CODE_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_HALTWAIT);
  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign fail_idx    = idx_q;
  assign fail_code   = code_q;
  assign cycle_count = cnt_q;

endmodule
